// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared core types: machine word and data-memory responder state.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dresp_state_t;
endpackage
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder between the MEM stage latch and the RAM
//               port; one RAM access per request, single-cycle dhit.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dREN,
  input  logic        dWEN,
  input  word_t       daddr,
  input  word_t       dstore,
  output logic        dhit,
  output word_t       dload,
  output logic        ramREN,
  output logic        ramWEN,
  output word_t       ramaddr,
  output word_t       ramstore,
  input  word_t       ramload,
  input  logic        ramready,
  output logic        err,
  output logic [31:0] hit_count
);

  dresp_state_t     r_state;
  dresp_state_t     w_next_state;
  logic             r_is_write;
  logic [CNT_W-1:0] r_wait_cnt;
  word_t            r_addr;
  word_t            r_store;
  word_t            r_dload;
  logic             r_ram_ren;
  logic             r_ram_wen;
  logic             r_err;
  logic [31:0]      r_hit_count;
  logic             w_req;
  logic             w_timeout;

  assign w_req     = dREN | dWEN;
  assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next_state = ACCESS;
      ACCESS:  if (ramready || w_timeout) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // A request withdrawn before RESP (pipeline flush) must not see a hit.
  assign dhit = (r_state == RESP) & w_req;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_is_write  <= 1'b0;
      r_wait_cnt  <= '0;
      r_addr      <= '0;
      r_store     <= '0;
      r_dload     <= '0;
      r_ram_ren   <= 1'b0;
      r_ram_wen   <= 1'b0;
      r_err       <= 1'b0;
      r_hit_count <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_is_write <= dWEN;
            r_addr     <= daddr;
            r_store    <= dstore;
            r_wait_cnt <= '0;
            r_ram_ren  <= ~dWEN;
            r_ram_wen  <= dWEN;
          end
        end
        ACCESS: begin
          if (ramready) begin
            if (!r_is_write) r_dload <= ramload;
            r_ram_ren <= 1'b0;
            r_ram_wen <= 1'b0;
          end else if (w_timeout) begin
            r_err     <= 1'b1;
            r_dload   <= '0;
            r_ram_ren <= 1'b0;
            r_ram_wen <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (dhit) r_hit_count <= r_hit_count + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign dload     = r_dload;
  assign ramREN    = r_ram_ren;
  assign ramWEN    = r_ram_wen;
  assign ramaddr   = r_addr;
  assign ramstore  = r_store;
  assign err       = r_err;
  assign hit_count = r_hit_count;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed bench for dmem_responder; two instances (timeout 64
//               and 4) share stimulus and are tracked by a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
  localparam int NI = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        dREN, dWEN, ramready;
  logic [31:0] daddr, dstore, ramload;

  logic        o_dhit   [NI];
  logic [31:0] o_dload  [NI];
  logic        o_ren    [NI];
  logic        o_wen    [NI];
  logic [31:0] o_addr   [NI];
  logic [31:0] o_store  [NI];
  logic        o_err    [NI];
  logic [31:0] o_hits   [NI];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 CLK = ~CLK;

  dmem_responder #(.TIMEOUT_CYCLES(64)) u_dut_64 (
    .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(o_dhit[0]), .dload(o_dload[0]), .ramREN(o_ren[0]), .ramWEN(o_wen[0]),
    .ramaddr(o_addr[0]), .ramstore(o_store[0]), .ramload(ramload), .ramready(ramready),
    .err(o_err[0]), .hit_count(o_hits[0])
  );

  dmem_responder #(.TIMEOUT_CYCLES(4)) u_dut_4 (
    .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(o_dhit[1]), .dload(o_dload[1]), .ramREN(o_ren[1]), .ramWEN(o_wen[1]),
    .ramaddr(o_addr[1]), .ramstore(o_store[1]), .ramload(ramload), .ramready(ramready),
    .err(o_err[1]), .hit_count(o_hits[1])
  );

  // Transaction model: one outstanding access, then one response cycle.
  bit          m_busy   [NI];
  bit          m_resp   [NI];
  bit          m_wr     [NI];
  bit          m_err    [NI];
  int          m_waited [NI];
  logic [31:0] m_addr   [NI];
  logic [31:0] m_data   [NI];
  logic [31:0] m_dload  [NI];
  logic [31:0] m_hits   [NI];

  function automatic int tmo(input int k);
    return (k == 0) ? 64 : 4;
  endfunction

  always @(posedge CLK) begin
    for (int k = 0; k < NI; k++) begin
      if (RST) begin
        m_busy[k]  <= 1'b0;
        m_resp[k]  <= 1'b0;
        m_wr[k]    <= 1'b0;
        m_err[k]   <= 1'b0;
        m_waited[k] <= 0;
        m_addr[k]  <= 32'd0;
        m_data[k]  <= 32'd0;
        m_dload[k] <= 32'd0;
        m_hits[k]  <= 32'd0;
      end else if (m_resp[k]) begin
        if (dREN || dWEN) m_hits[k] <= m_hits[k] + 32'd1;
        m_resp[k] <= 1'b0;
      end else if (m_busy[k]) begin
        if (ramready) begin
          if (!m_wr[k]) m_dload[k] <= ramload;
          m_busy[k] <= 1'b0;
          m_resp[k] <= 1'b1;
        end else if (m_waited[k] + 1 == tmo(k)) begin
          m_err[k]   <= 1'b1;
          m_dload[k] <= 32'd0;
          m_busy[k]  <= 1'b0;
          m_resp[k]  <= 1'b1;
        end else begin
          m_waited[k] <= m_waited[k] + 1;
        end
      end else if (dREN || dWEN) begin
        m_busy[k]   <= 1'b1;
        m_wr[k]     <= dWEN;
        m_addr[k]   <= daddr;
        m_data[k]   <= dstore;
        m_waited[k] <= 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        check($sformatf("dhit[%0d]", k),      32'(o_dhit[k]), 32'(m_resp[k] & (dREN | dWEN)));
        check($sformatf("dload[%0d]", k),     o_dload[k], m_dload[k]);
        check($sformatf("ramREN[%0d]", k),    32'(o_ren[k]), 32'(m_busy[k] & ~m_wr[k]));
        check($sformatf("ramWEN[%0d]", k),    32'(o_wen[k]), 32'(m_busy[k] & m_wr[k]));
        check($sformatf("ramaddr[%0d]", k),   o_addr[k], m_addr[k]);
        check($sformatf("ramstore[%0d]", k),  o_store[k], m_data[k]);
        check($sformatf("err[%0d]", k),       32'(o_err[k]), 32'(m_err[k]));
        check($sformatf("hit_count[%0d]", k), o_hits[k], m_hits[k]);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    tick();
    RST = 1'b1; dREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  int          n;
  logic [6:0]  seen;

  initial begin
    RST = 1'b1; dREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;
    daddr = '0; dstore = '0; ramload = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk_en = 1'b1;
    @(negedge CLK);
    check("reset_hits", o_hits[0], 32'd0);
    check("reset_err", 32'(o_err[1]), 32'd0);

    // Single read, ready in cycle 1, hit in cycle 2.
    tick(); dREN = 1'b1; daddr = 32'h40;
    tick(); ramready = 1'b1; ramload = 32'hDEADBEEF;
    @(negedge CLK);
    check("t1_ren_c1", 32'(o_ren[0]), 32'd1);
    check("t1_dhit_c1", 32'(o_dhit[0]), 32'd0);
    tick(); ramready = 1'b0; ramload = 32'd0;
    @(negedge CLK);
    check("t1_dhit_c2", 32'(o_dhit[0]), 32'd1);
    check("t1_dload", o_dload[0], 32'hDEADBEEF);
    tick(); dREN = 1'b0;
    @(negedge CLK);
    check("t1_dhit_c3", 32'(o_dhit[0]), 32'd0);
    check("t1_hits", o_hits[0], 32'd1);

    // Flush: request dropped in the second access cycle.
    tick(); dREN = 1'b1; daddr = 32'h44;
    tick();
    tick(); dREN = 1'b0;
    tick(); ramready = 1'b1; ramload = 32'h55;
    @(negedge CLK);
    check("t4_ren_c3", 32'(o_ren[0]), 32'd1);
    tick(); ramready = 1'b0;
    @(negedge CLK);
    check("t4_no_dhit", 32'(o_dhit[0]), 32'd0);
    tick();
    @(negedge CLK);
    check("t4_hits", o_hits[0], 32'd1);
    check("t4_ren_idle", 32'(o_ren[0]), 32'd0);

    // Back-to-back reads with dREN held high.
    for (int c = 0; c < 7; c++) begin
      tick();
      dREN     = (c < 6);
      daddr    = 32'h48;
      ramready = (c == 1 || c == 4);
      ramload  = (c == 4) ? 32'hB0B0_0002 : 32'hA0A0_0001;
      @(negedge CLK);
      seen[c] = o_dhit[0];
    end
    check("t6_pattern", 32'(seen), 32'h24);
    check("t6_dload", o_dload[0], 32'hB0B0_0002);
    check("t6_hits", o_hits[0], 32'd3);

    // Write with five access cycles; address/data changes mid-access ignored.
    do_reset();
    n = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      dWEN     = (c <= 6);
      daddr    = (c == 0) ? 32'h100 : 32'h999;
      dstore   = (c == 0) ? 32'h1234 : 32'h5;
      ramready = (c == 5);
      @(negedge CLK);
      if (o_wen[0]) n++;
      if (c == 3) begin
        check("t2_ramaddr", o_addr[0], 32'h100);
        check("t2_ramstore", o_store[0], 32'h1234);
      end
      if (c == 6) check("t2_dhit", 32'(o_dhit[0]), 32'd1);
    end
    check("t2_wen_cycles", 32'(n), 32'd5);

    // Timeout on the 4-cycle instance, then a later read still served.
    do_reset();
    n = 0;
    for (int c = 0; c < 7; c++) begin
      tick();
      dREN = (c <= 5); daddr = 32'h200; ramready = 1'b0;
      @(negedge CLK);
      if (o_ren[1]) n++;
      if (c == 5) begin
        check("t3_dhit", 32'(o_dhit[1]), 32'd1);
        check("t3_dload", o_dload[1], 32'd0);
        check("t3_err", 32'(o_err[1]), 32'd1);
      end
    end
    check("t3_ren_cycles", 32'(n), 32'd4);
    tick(); dREN = 1'b1; daddr = 32'h204;
    tick(); ramready = 1'b1; ramload = 32'hCAFE0001;
    tick(); ramready = 1'b0;
    @(negedge CLK);
    check("t3_later_dhit", 32'(o_dhit[1]), 32'd1);
    check("t3_later_dload", o_dload[1], 32'hCAFE0001);
    check("t3_err_sticky", 32'(o_err[1]), 32'd1);
    tick(); dREN = 1'b0;

    // Reset in the middle of a write access.
    do_reset();
    tick(); dWEN = 1'b1; daddr = 32'h300; dstore = 32'hABCD;
    tick();
    @(negedge CLK);
    check("t5_wen_c1", 32'(o_wen[0]), 32'd1);
    check("t5_addr_c1", o_addr[0], 32'h300);
    tick(); RST = 1'b1;
    tick(); RST = 1'b0; dWEN = 1'b0;
    @(negedge CLK);
    check("t5_wen_after_rst", 32'(o_wen[0]), 32'd0);
    check("t5_addr_after_rst", o_addr[0], 32'd0);
    check("t5_store_after_rst", o_store[0], 32'd0);
    tick(); dREN = 1'b1; daddr = 32'h304;
    tick(); ramready = 1'b1; ramload = 32'h77;
    tick(); ramready = 1'b0;
    @(negedge CLK);
    check("t5_dhit", 32'(o_dhit[0]), 32'd1);
    check("t5_dload", o_dload[0], 32'h77);
    tick(); dREN = 1'b0;
    @(negedge CLK);
    check("t5_hits", o_hits[0], 32'd1);

    // dREN and dWEN together behave as a write.
    tick(); dREN = 1'b1; dWEN = 1'b1; daddr = 32'h308; dstore = 32'h1;
    tick(); ramready = 1'b1; ramload = 32'hFFFF_0000;
    @(negedge CLK);
    check("t7_wen", 32'(o_wen[0]), 32'd1);
    check("t7_ren", 32'(o_ren[0]), 32'd0);
    tick(); ramready = 1'b0;
    @(negedge CLK);
    check("t7_dhit", 32'(o_dhit[0]), 32'd1);
    check("t7_dload_kept", o_dload[0], 32'h77);
    tick(); dREN = 1'b0; dWEN = 1'b0;
    @(negedge CLK);
    check("t7_hits", o_hits[0], 32'd2);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
